// File: rtl/feature_fetcher_if.sv
// Bundle between the feature fetcher, the new-feature BRAM read port and the
// downstream vector consumer. "master" is the fetcher side, "slave" the
// BRAM/consumer side.
//
// Vector handshake: a transfer happens on every rising clk edge where
// feat_vec_vld && feat_vec_rdy. While feat_vec_vld is high and feat_vec_rdy is
// low, feat_vec and node_idx stay stable and feat_vec_vld stays high. Only a
// transfer or reset drops feat_vec_vld. feat_vec_rdy has no effect while
// feat_vec_vld is low.
interface feature_fetcher_if #(
   parameter int NEW_FEATURE_WIDTH = 32,
   parameter int NUM_FEATURE_OUT   = 16,
   parameter int NUM_SUBGRAPHS     = 2708
);
   localparam int ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT);
   localparam int IDX_W  = $clog2(NUM_SUBGRAPHS);

   logic [ADDR_W-1:0]                                 feat_bram_addrb;
   logic                                              feat_bram_enb;
   logic [NEW_FEATURE_WIDTH-1:0]                      feat_bram_doutb;
   logic [NUM_FEATURE_OUT-1:0][NEW_FEATURE_WIDTH-1:0] feat_vec;
   logic                                              feat_vec_vld;
   logic                                              feat_vec_rdy;
   logic [IDX_W-1:0]                                  node_idx;

   modport master (
      output feat_bram_addrb, feat_bram_enb, feat_vec, feat_vec_vld, node_idx,
      input  feat_bram_doutb, feat_vec_rdy
   );

   modport slave (
      input  feat_bram_addrb, feat_bram_enb, feat_vec, feat_vec_vld, node_idx,
      output feat_bram_doutb, feat_vec_rdy
   );
endinterface

// File: rtl/feature_fetcher.sv
// Feature fetcher: walks the new-feature BRAM node by node, issues one
// single-element read per cycle, reassembles each node's elements into one
// packed vector and offers it downstream over valid/ready.
// Word k of node n (address n*N+k) holds element N-1-k and lands in
// feat_vec[N-1-k]. Reads never overlap the OUT phase, so a single vector
// buffer is enough even under backpressure.
module feature_fetcher #(
   parameter int NEW_FEATURE_WIDTH = 32,
   parameter int NUM_FEATURE_OUT   = 16,
   parameter int NUM_SUBGRAPHS     = 2708,
   parameter int BRAM_RD_LATENCY   = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               start,
   feature_fetcher_if.master  bus,
   output logic               busy,
   output logic               done,
   output logic [2:0]         state_dbg
);
   localparam int NEW_FEATURE_ADDR_W = $clog2(NUM_SUBGRAPHS * NUM_FEATURE_OUT);
   localparam int IDX_W              = $clog2(NUM_SUBGRAPHS);
   localparam int CNT_W              = $clog2(NUM_FEATURE_OUT);
   localparam logic [IDX_W-1:0] LAST_NODE = IDX_W'(NUM_SUBGRAPHS - 1);
   localparam logic [CNT_W-1:0] LAST_CNT  = CNT_W'(NUM_FEATURE_OUT - 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_WAIT  = 3'd2,
      S_OUT   = 3'd3,
      S_FIN   = 3'd4
   } state_t;

   state_t                        state;
   logic [CNT_W-1:0]              rd_cnt;
   logic [CNT_W-1:0]              ret_cnt;
   logic [NEW_FEATURE_ADDR_W-1:0] nxt_addr;
   logic [BRAM_RD_LATENCY-1:0]    vld_pipe;
   logic                          ret_vld;

   assign state_dbg = state;
   assign ret_vld   = vld_pipe[BRAM_RD_LATENCY-1];

   // Delay line matching BRAM latency: tags which cycles carry requested read data.
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_pipe <= '0;
      end else begin
         vld_pipe[0] <= bus.feat_bram_enb;
         for (int i = 1; i < BRAM_RD_LATENCY; i++) begin
            vld_pipe[i] <= vld_pipe[i-1];
         end
      end
   end

   // Main FSM: issues reads, captures returning words, runs the output handshake.
   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= S_IDLE;
         bus.feat_bram_enb   <= 1'b0;
         bus.feat_bram_addrb <= '0;
         bus.feat_vec        <= '0;
         bus.feat_vec_vld    <= 1'b0;
         bus.node_idx        <= '0;
         nxt_addr            <= '0;
         rd_cnt              <= '0;
         ret_cnt             <= '0;
         busy                <= 1'b0;
         done                <= 1'b0;
      end else begin
         done <= 1'b0;

         // Returning words fill the buffer from the top slot down (slot N-1-k == ~k).
         if (ret_vld) begin
            bus.feat_vec[~ret_cnt] <= bus.feat_bram_doutb;
            ret_cnt                <= ret_cnt + 1'b1;
         end

         case (state)
            S_IDLE: begin
               if (start) begin
                  state               <= S_FETCH;
                  bus.feat_bram_enb   <= 1'b1;
                  bus.feat_bram_addrb <= '0;
                  bus.node_idx        <= '0;
                  rd_cnt              <= '0;
                  busy                <= 1'b1;
               end
            end

            S_FETCH: begin
               if (rd_cnt == LAST_CNT) begin
                  state               <= S_WAIT;
                  bus.feat_bram_enb   <= 1'b0;
                  bus.feat_bram_addrb <= '0;
                  nxt_addr            <= bus.feat_bram_addrb + NEW_FEATURE_ADDR_W'(1);
                  rd_cnt              <= '0;
               end else begin
                  rd_cnt              <= rd_cnt + 1'b1;
                  bus.feat_bram_addrb <= bus.feat_bram_addrb + NEW_FEATURE_ADDR_W'(1);
               end
            end

            S_WAIT: begin
               if (ret_vld && (ret_cnt == LAST_CNT)) begin
                  state            <= S_OUT;
                  bus.feat_vec_vld <= 1'b1;
               end
            end

            S_OUT: begin
               if (bus.feat_vec_vld && bus.feat_vec_rdy) begin
                  bus.feat_vec_vld <= 1'b0;
                  if (bus.node_idx == LAST_NODE) begin
                     state <= S_FIN;
                     done  <= 1'b1;
                  end else begin
                     state               <= S_FETCH;
                     bus.node_idx        <= bus.node_idx + 1'b1;
                     bus.feat_bram_enb   <= 1'b1;
                     bus.feat_bram_addrb <= nxt_addr;
                  end
               end
            end

            S_FIN: begin
               state <= S_IDLE;
               busy  <= 1'b0;
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_feature_fetcher.sv
// Bench for feature_fetcher: small configuration (N=4, 3 nodes, latency 2),
// BRAM model returning 100+address, expected vectors queued per run.
module tb_feature_fetcher;
   localparam int W  = 32;
   localparam int N  = 4;
   localparam int NS = 3;
   localparam int L  = 2;
   localparam int VW = N * W;

   logic       clk = 1'b0;
   logic       rst;
   logic       start;
   logic       busy;
   logic       done;
   logic [2:0] state_dbg;

   feature_fetcher_if #(.NEW_FEATURE_WIDTH(W), .NUM_FEATURE_OUT(N), .NUM_SUBGRAPHS(NS)) bus ();

   feature_fetcher #(
      .NEW_FEATURE_WIDTH(W),
      .NUM_FEATURE_OUT(N),
      .NUM_SUBGRAPHS(NS),
      .BRAM_RD_LATENCY(L)
   ) dut (
      .clk(clk),
      .rst(rst),
      .start(start),
      .bus(bus),
      .busy(busy),
      .done(done),
      .state_dbg(state_dbg)
   );

   // ---------------- clock / cycle counter ----------------
   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- BRAM model: two-stage read pipe ----------------
   logic [W-1:0] rd_stage1;
   always @(posedge clk) begin
      rd_stage1           <= bus.feat_bram_enb ? (W'(100) + W'(bus.feat_bram_addrb)) : 32'hDEAD_BEEF;
      bus.feat_bram_doutb <= rd_stage1;
   end

   // ---------------- scoreboard ----------------
   logic [VW-1:0] exp_q[$];
   int            exp_idx_q[$];
   int            exp_addr_q[$];
   int            n_checks = 0;
   int            n_errors = 0;
   int            hs_cnt = 0;
   int            done_cnt = 0;
   int            last_hs_cyc = -10;

   task automatic check(input string tag, input logic [VW-1:0] got, input logic [VW-1:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   task automatic push_run();
      logic [N-1:0][W-1:0] v;
      for (int n = 0; n < NS; n++) begin
         for (int k = 0; k < N; k++) begin
            exp_addr_q.push_back(n * N + k);
            v[N-1-k] = W'(100 + n * N + k);
         end
         exp_q.push_back(v);
         exp_idx_q.push_back(n);
      end
   endtask

   task automatic clear_sb();
      exp_q.delete();
      exp_idx_q.delete();
      exp_addr_q.delete();
      hs_cnt   = 0;
      done_cnt = 0;
   endtask

   // ---------------- monitor (samples on falling edge) ----------------
   logic          hold_prev = 1'b0;
   logic [VW-1:0] prev_vec;
   int            prev_idx;

   always @(negedge clk) begin
      if (rst) begin
         hold_prev = 1'b0;
      end else begin
         if (bus.feat_bram_enb) begin
            if (exp_addr_q.size() == 0) check("extra_read", exp_addr_q.size(), 1);
            else check("rd_addr", bus.feat_bram_addrb, exp_addr_q.pop_front());
         end
         if (hold_prev) begin
            check("hold_vld", bus.feat_vec_vld, 1);
            check("hold_vec", bus.feat_vec, prev_vec);
            check("hold_idx", bus.node_idx, prev_idx);
         end
         if (bus.feat_vec_vld) check("enb_during_out", bus.feat_bram_enb, 0);
         if (bus.feat_vec_vld && bus.feat_vec_rdy) begin
            hs_cnt++;
            last_hs_cyc = cyc;
            if (exp_q.size() == 0) begin
               check("extra_vector", exp_q.size(), 1);
            end else begin
               check("feat_vec", bus.feat_vec, exp_q.pop_front());
               check("node_idx", bus.node_idx, exp_idx_q.pop_front());
            end
         end
         if (done) begin
            done_cnt++;
            check("done_after_hs", cyc, last_hs_cyc + 1);
         end
         hold_prev = bus.feat_vec_vld && !bus.feat_vec_rdy;
         prev_vec  = bus.feat_vec;
         prev_idx  = int'(bus.node_idx);
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_vld(output int cycles);
      cycles = 0;
      while (!bus.feat_vec_vld && cycles < 60) begin
         tick();
         cycles++;
      end
      if (!bus.feat_vec_vld) check("vld_timeout", bus.feat_vec_vld, 1);
   endtask

   task automatic wait_done(input int target);
      int i;
      i = 0;
      while (done_cnt < target && i < 300) begin
         tick();
         i++;
      end
      repeat (3) tick();
      check("done_count", done_cnt, target);
   endtask

   task automatic end_of_run_checks(input string tag);
      check({tag, "_hs_count"}, hs_cnt, NS);
      check({tag, "_busy_low"}, busy, 0);
      check({tag, "_vec_q_empty"}, exp_q.size(), 0);
      check({tag, "_addr_q_empty"}, exp_addr_q.size(), 0);
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int lat;
      int found;
      rst = 1'b1;
      start = 1'b1;
      bus.feat_vec_rdy = 1'b0;

      // Reset held with start high: everything stays quiet.
      repeat (3) tick();
      check("rst_enb", bus.feat_bram_enb, 0);
      check("rst_vld", bus.feat_vec_vld, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_node_idx", bus.node_idx, 0);
      check("rst_addrb", bus.feat_bram_addrb, 0);
      check("rst_state", state_dbg, 0);
      rst = 1'b0;
      start = 1'b0;
      tick();

      // Single vector, backpressure, ignored starts.
      clear_sb();
      push_run();
      pulse_start();
      check("enb_cycle1", bus.feat_bram_enb, 1);
      check("busy_cycle1", busy, 1);
      wait_vld(lat);
      check("first_vld_latency", lat + 1, N + L + 1);
      check("first_node_idx", bus.node_idx, 0);
      for (int i = 0; i < 10; i++) begin
         start = (i == 4);
         tick();
      end
      start = 1'b0;
      check("bp_vld_held", bus.feat_vec_vld, 1);
      check("bp_hs_none", hs_cnt, 0);
      bus.feat_vec_rdy = 1'b1;
      tick();
      bus.feat_vec_rdy = 1'b0;
      check("one_hs", hs_cnt, 1);
      check("vld_drop_after_hs", bus.feat_vec_vld, 0);
      pulse_start();
      wait_vld(lat);
      check("node1_vld_latency", cyc - last_hs_cyc, N + L + 1);
      check("node1_idx", bus.node_idx, 1);
      bus.feat_vec_rdy = 1'b1;
      wait_done(1);
      end_of_run_checks("bp_run");

      // Full run, ready always high.
      clear_sb();
      push_run();
      pulse_start();
      wait_done(1);
      end_of_run_checks("full_run");

      // Random ready.
      clear_sb();
      push_run();
      pulse_start();
      for (int i = 0; i < 300 && done_cnt == 0; i++) begin
         bus.feat_vec_rdy = 1'($urandom_range(0, 1));
         tick();
      end
      bus.feat_vec_rdy = 1'b1;
      wait_done(1);
      end_of_run_checks("rand_run");

      // Reset during WAIT of node 1, then a clean restart.
      clear_sb();
      push_run();
      pulse_start();
      found = 0;
      for (int i = 0; i < 100 && found == 0; i++) begin
         if (state_dbg == 3'd2 && bus.node_idx == 1) found = 1;
         else tick();
      end
      check("reached_wait_node1", found, 1);
      rst = 1'b1;
      tick();
      tick();
      clear_sb();
      check("midrst_vld", bus.feat_vec_vld, 0);
      check("midrst_busy", busy, 0);
      check("midrst_node_idx", bus.node_idx, 0);
      check("midrst_state", state_dbg, 0);
      rst = 1'b0;
      repeat (6) tick();
      check("postrst_vld", bus.feat_vec_vld, 0);
      check("postrst_enb", bus.feat_bram_enb, 0);
      push_run();
      pulse_start();
      wait_done(1);
      end_of_run_checks("restart_run");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule
